// File: rtl/vec_imm_pkg.sv
// ----------------------------------------------------------------------------
// vec_imm_pkg
//   Shared types and defaults for the vector immediate extender.
//   - imm_src_e     : extend mode carried alongside each immediate
//   - *_DEF         : default geometry (32 lanes x 8 bits = 256-bit operand)
//   - vword_t       : full-width operand at the default geometry
//   - BUF_DEPTH     : entries in the elastic buffer between decode and execute
//   - count_step()  : occupancy update for a push/pop pair
// ----------------------------------------------------------------------------
package vec_imm_pkg;

    typedef enum logic [1:0] {
        IMM7  = 2'b00,   // zero-extend instr[6:0]
        IMM11 = 2'b01,   // zero-extend instr[10:0]
        BR    = 2'b10,   // sign-extend whole field, then scale by branch shift
        BCAST = 2'b11    // replicate low lane-width bits into every lane
    } imm_src_e;

    localparam int LANES_DEF   = 32;
    localparam int LANE_W_DEF  = 8;
    localparam int VW_DEF      = LANES_DEF * LANE_W_DEF;
    localparam int INSTR_W_DEF = 21;
    localparam int B_SHIFT_DEF = 2;

    typedef logic [VW_DEF-1:0] vword_t;

    // Two entries let the producer keep streaming at one per cycle while
    // in_ready stays a pure flop output (no path from out_ready).
    localparam int BUF_DEPTH = 2;

    // Occupancy after one cycle of push/pop. Callers guarantee no overflow
    // (push is gated by in_ready) and no underflow (pop is gated by out_valid).
    function automatic logic [1:0] count_step(input logic [1:0] cnt,
                                              input logic       inc,
                                              input logic       dec);
        logic [1:0] nxt;
        nxt = cnt;
        case ({inc, dec})
            2'b10:   nxt = cnt + 2'd1;
            2'b01:   nxt = cnt - 2'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vec_imm_decode.sv
// ----------------------------------------------------------------------------
// vec_imm_decode
//   Purely combinational immediate extender. Widens the instruction immediate
//   field to a full vector-width operand according to imm_src.
// Ports
//   instr    in   INSTR_W        immediate field of the instruction
//   imm_src  in   2              extend mode (imm_src_e encoding)
//   ext_imm  out  LANES*LANE_W   extended operand
// ----------------------------------------------------------------------------
module vec_imm_decode
    import vec_imm_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int LANE_W  = LANE_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int B_SHIFT = B_SHIFT_DEF
) (
    input  logic [INSTR_W-1:0]      instr,
    input  logic [1:0]              imm_src,
    output logic [LANES*LANE_W-1:0] ext_imm
);

    localparam int VW = LANES * LANE_W;

    // Geometry guards: the scaled branch offset must fit, and the field must
    // cover the widest zero-extend source and a full broadcast lane.
    if (VW < INSTR_W + B_SHIFT) begin : g_chk_vw
        $error("vec_imm_decode: VW (%0d) < INSTR_W+B_SHIFT (%0d)", VW, INSTR_W + B_SHIFT);
    end
    if (INSTR_W < 11) begin : g_chk_iw
        $error("vec_imm_decode: INSTR_W (%0d) must be >= 11", INSTR_W);
    end
    if (INSTR_W < LANE_W) begin : g_chk_lw
        $error("vec_imm_decode: INSTR_W (%0d) must be >= LANE_W (%0d)", INSTR_W, LANE_W);
    end

    logic [VW-1:0]                imm7_w;
    logic [VW-1:0]                imm11_w;
    logic [VW-1:0]                br_sx;
    logic [VW-1:0]                br_w;
    logic [LANES-1:0][LANE_W-1:0] bcast_w;

    assign imm7_w  = {{(VW-7){1'b0}},  instr[6:0]};
    assign imm11_w = {{(VW-11){1'b0}}, instr[10:0]};

    // The sign bit is folded into the replication so the count is never zero,
    // even when VW == INSTR_W.
    assign br_sx = {{(VW-INSTR_W+1){instr[INSTR_W-1]}}, instr[INSTR_W-2:0]};
    assign br_w  = br_sx << B_SHIFT;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign bcast_w[i] = instr[LANE_W-1:0];
    end

    always_comb begin
        ext_imm = imm7_w;
        case (imm_src_e'(imm_src))
            IMM7:    ext_imm = imm7_w;
            IMM11:   ext_imm = imm11_w;
            BR:      ext_imm = br_w;
            BCAST:   ext_imm = bcast_w;
            default: ext_imm = imm7_w;
        endcase
    end

endmodule

// File: rtl/vec_imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// vec_imm_extend_pipe
//   Flow-controlled immediate extender between decode and the vector execute
//   operand mux. Immediates are extended on the way in and held in a 2-entry
//   elastic buffer; the head entry is presented from output registers.
// Ports
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   in_valid   in   1             instr/imm_src valid
//   in_ready   out  1             buffer can accept (registered, count < 2)
//   instr      in   INSTR_W       immediate field of instruction
//   imm_src    in   2             extend mode (imm_src_e)
//   out_valid  out  1             ext_imm valid
//   out_ready  in   1             consumer accepts
//   ext_imm    out  LANES*LANE_W  extended immediate of the head entry
//   out_mode   out  2             imm_src of the head entry
// ----------------------------------------------------------------------------
module vec_imm_extend_pipe
    import vec_imm_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int LANE_W  = LANE_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int B_SHIFT = B_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      instr,
    input  logic [1:0]              imm_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] ext_imm,
    output logic [1:0]              out_mode
);

    localparam int         VW   = LANES * LANE_W;
    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    typedef struct packed {
        logic [1:0]    mode;
        logic [VW-1:0] imm;
    } entry_t;

    entry_t [BUF_DEPTH-1:0] mem_q;
    entry_t [BUF_DEPTH-1:0] mem_d;
    entry_t                 dec_e;
    entry_t                 head_e;

    logic          head_q, head_d;
    logic          tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;
    logic [VW-1:0] dec_imm;

    vec_imm_decode #(
        .LANES   (LANES),
        .LANE_W  (LANE_W),
        .INSTR_W (INSTR_W),
        .B_SHIFT (B_SHIFT)
    ) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .ext_imm (dec_imm)
    );

    assign dec_e = '{mode: imm_src, imm: dec_imm};

    // in_ready and out_valid are flops, so neither handshake term depends
    // combinationally on the opposite side.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state of the whole buffer is formed first so the output registers
    // can load the post-update head directly. This covers the bypass cases
    // (write into an empty buffer, or push+pop at count 1) without special
    // casing: the freshly written slot is already visible in mem_d.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = dec_e;
        end
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_step(count_q, push, pop);
        head_e  = mem_d[head_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            ext_imm   <= '0;
            out_mode  <= 2'd0;
        end else begin
            mem_q     <= mem_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            in_ready  <= (count_d != FULL);
            out_valid <= (count_d != 2'd0);
            // When the buffer drains the last presented value is held; it is
            // meaningless to the consumer but avoids needless toggling.
            if (count_d != 2'd0) begin
                ext_imm  <= head_e.imm;
                out_mode <= head_e.mode;
            end
        end
    end

endmodule

// File: tb/tb_vec_imm_extend_pipe.sv
module tb_vec_imm_extend_pipe;

    logic         clk;
    logic         rst_n;

    // default geometry instance (256-bit)
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [20:0]  instr;
    logic [1:0]   imm_src, out_mode;
    logic [255:0] ext_imm;

    // narrow geometry instance (4 x 16 = 64-bit)
    logic         in2_valid, in2_ready, out2_valid, out2_ready;
    logic [20:0]  instr2;
    logic [1:0]   imm_src2, out2_mode;
    logic [63:0]  ext2_imm;

    typedef struct {
        logic [255:0] imm;
        logic [1:0]   mode;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vec_imm_extend_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_imm   (ext_imm),
        .out_mode  (out_mode)
    );

    vec_imm_extend_pipe #(.LANES(4), .LANE_W(16), .INSTR_W(21), .B_SHIFT(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in2_valid),
        .in_ready  (in2_ready),
        .instr     (instr2),
        .imm_src   (imm_src2),
        .out_valid (out2_valid),
        .out_ready (out2_ready),
        .ext_imm   (ext2_imm),
        .out_mode  (out2_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] model(input logic [20:0] i, input logic [1:0] m);
        logic [255:0] r;
        r = '0;
        case (m)
            2'd0: r = 256'(i[6:0]);
            2'd1: r = 256'(i[10:0]);
            2'd2: begin
                r = {{235{i[20]}}, i};
                r = r << 2;
            end
            default: for (int k = 0; k < 32; k++) r[k*8 +: 8] = i[7:0];
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard pop/compare and push at the negedge (inputs are
    // stable there and match what the next posedge will see), then advance
    // to just after the posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 256'(1), 256'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_imm", ext_imm, e.imm);
                chk("sb_mode", 256'(out_mode), 256'(e.mode));
            end
        end
        if (in_valid && in_ready) begin
            e.imm  = model(instr, imm_src);
            e.mode = imm_src;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
        chk("drain_left", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        logic [255:0] e256;
        logic [255:0] a_hold;

        rst_n = 1'b1;
        in_valid = 1'b0; instr = '0; imm_src = 2'd0; out_ready = 1'b0;
        in2_valid = 1'b0; instr2 = '0; imm_src2 = 2'd0; out2_ready = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_ext_imm", ext_imm, 256'(0));
        chk("rst_out_mode", 256'(out_mode), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 256'(in_ready), 256'(1));
        chk("rel_out_valid", 256'(out_valid), 256'(0));

        // IMM7, one-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 21'h0007F; imm_src = 2'd0;
        cyc();
        in_valid = 1'b0;
        chk("imm7_valid", 256'(out_valid), 256'(1));
        chk("imm7_val", ext_imm, 256'h7F);
        chk("imm7_mode", 256'(out_mode), 256'(0));
        cyc();

        // IMM11 with high field bits set that must not leak through
        in_valid = 1'b1; instr = 21'h1FFFFF; imm_src = 2'd1;
        cyc();
        in_valid = 1'b0;
        chk("imm11_val", ext_imm, 256'h7FF);
        cyc();

        // BR negative then +1 back to back
        in_valid = 1'b1; instr = 21'h100000; imm_src = 2'd2;
        cyc();
        e256 = {{233{1'b1}}, 23'h400000};
        chk("br_neg", ext_imm, e256);
        chk("br_mode", 256'(out_mode), 256'(2));
        instr = 21'h000001;
        cyc();
        in_valid = 1'b0;
        chk("br_pos", ext_imm, 256'h4);
        cyc();

        // BCAST on both geometries; BR on the narrow one
        in_valid = 1'b1; instr = 21'h000A5; imm_src = 2'd3;
        in2_valid = 1'b1; instr2 = 21'h1234A5; imm_src2 = 2'd3;
        cyc();
        in_valid = 1'b0;
        e256 = {32{8'hA5}};
        chk("bcast_256", ext_imm, e256);
        chk("bcast_64", 256'(ext2_imm), 256'(64'h34A5_34A5_34A5_34A5));
        instr2 = 21'h0000A5;
        cyc();
        chk("bcast_64b", 256'(ext2_imm), 256'({4{16'h00A5}}));
        instr2 = 21'h100000; imm_src2 = 2'd2;
        cyc();
        in2_valid = 1'b0;
        chk("br_64", 256'(ext2_imm), 256'(64'hFFFF_FFFF_FFC0_0000));
        drain();

        // Backpressure: A, B fill the buffer, C is refused
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 21'h0ABCD; imm_src = 2'd1;
        cyc();
        a_hold = ext_imm;
        chk("bp_a_head", ext_imm, 256'h3CD);
        chk("bp_ready_1", 256'(in_ready), 256'(1));
        instr = 21'h00055; imm_src = 2'd0;
        cyc();
        chk("bp_full", 256'(in_ready), 256'(0));
        instr = 21'h1FFFF; imm_src = 2'd3;
        cyc();
        cyc();
        chk("bp_stable", ext_imm, a_hold);
        chk("bp_stable_mode", 256'(out_mode), 256'(1));
        chk("bp_sb_depth", 256'(sb.size()), 256'(2));
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bp_b_head", ext_imm, 256'h55);
        cyc();
        chk("bp_no_c", 256'(out_valid), 256'(0));
        chk("bp_sb_empty", 256'(sb.size()), 256'(0));

        // Streaming at count 1: one in, one out every cycle
        out_ready = 1'b1; imm_src = 2'd0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr = 21'(i);
            cyc();
            chk("stream_val", ext_imm, 256'(i));
            chk("stream_ready", 256'(in_ready), 256'(1));
            chk("stream_vld", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_end", 256'(out_valid), 256'(0));

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            instr     = 21'($urandom);
            imm_src   = 2'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        drain();

        // Reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 21'h00011; imm_src = 2'd0;
        cyc();
        instr = 21'h00022;
        cyc();
        in_valid = 1'b0;
        chk("mr_full", 256'(in_ready), 256'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 256'(out_valid), 256'(0));
        chk("mr_ext_imm", ext_imm, 256'(0));
        chk("mr_in_ready", 256'(in_ready), 256'(0));
        sb.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_rel_ready", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mr_no_stale", 256'(out_valid), 256'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
